// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [2:0] {
        BOOT,
        ISSUE,
        WAIT,
        HOLD,
        DRAIN,
        HALT
    } fetch_state_t;

    localparam int                 INSTR_W = 32;
    localparam int                 PC_INC  = 4;
    localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0013;

    // Instruction addresses must be word aligned.
    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: drives the PC, runs req/ack reads to instruction memory,
// holds the fetched word for decode and applies execute-stage redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                  Reg_size  = 32,
    parameter logic [Reg_size-1:0] Reset_vec = '0,
    parameter int                  Timeout   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [Reg_size-1:0] pc_out,
    output logic                pc_en,
    output logic [Reg_size-1:0] pc_next,
    output logic                imem_req,
    output logic [Reg_size-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  instr,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                stall,
    input  logic                redirect,
    input  logic [Reg_size-1:0] redirect_target,
    output logic                fault
);

    localparam int               CNT_W    = $clog2(Timeout + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Timeout - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    fetch_state_t          r_state;
    fetch_state_t          w_state_nx;
    logic [Reg_size-1:0]   r_addr;
    logic [Reg_size-1:0]   w_addr_nx;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic [CNT_W-1:0]      w_wait_cnt_nx;
    logic [INSTR_W-1:0]    r_instr;
    logic [INSTR_W-1:0]    w_instr_nx;
    logic                  r_instr_valid;
    logic                  w_instr_valid_nx;
    logic                  r_fault;
    logic                  w_fault_nx;
    logic                  w_redir_bad;
    logic                  w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= BOOT;
            r_addr        <= '0;
            r_wait_cnt    <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_addr        <= w_addr_nx;
            r_wait_cnt    <= w_wait_cnt_nx;
            r_instr       <= w_instr_nx;
            r_instr_valid <= w_instr_valid_nx;
            r_fault       <= w_fault_nx;
        end
    end

    always_comb begin
        w_state_nx       = r_state;
        w_addr_nx        = r_addr;
        w_wait_cnt_nx    = r_wait_cnt;
        w_instr_nx       = r_instr;
        w_instr_valid_nx = r_instr_valid;
        w_fault_nx       = r_fault;
        pc_en            = 1'b0;
        pc_next          = pc_out + Reg_size'(PC_INC);
        imem_req         = 1'b0;
        w_redir_bad      = redirect && misaligned(redirect_target[1:0]);
        w_timeout        = !imem_ack && (r_wait_cnt == CNT_LAST);

        case (r_state)
            BOOT: begin
                // Load the PC ourselves so its own reset value never matters.
                pc_en      = 1'b1;
                pc_next    = Reset_vec;
                w_state_nx = ISSUE;
            end

            ISSUE: begin
                if (redirect) begin
                    if (w_redir_bad) begin
                        w_fault_nx = 1'b1;
                        w_state_nx = HALT;
                    end else begin
                        pc_en      = 1'b1;
                        pc_next    = redirect_target;
                        w_state_nx = ISSUE;
                    end
                end else begin
                    w_addr_nx     = pc_out;
                    w_wait_cnt_nx = '0;
                    w_state_nx    = WAIT;
                end
            end

            WAIT: begin
                imem_req      = 1'b1;
                w_wait_cnt_nx = r_wait_cnt + CNT_ONE;
                if (redirect) begin
                    w_instr_valid_nx = 1'b0;
                    if (w_redir_bad) begin
                        w_fault_nx = 1'b1;
                        w_state_nx = (imem_ack || w_timeout) ? HALT : DRAIN;
                    end else begin
                        pc_en      = 1'b1;
                        pc_next    = redirect_target;
                        // A completing read is dropped; an open one must finish in DRAIN.
                        if (imem_ack) begin
                            w_state_nx = ISSUE;
                        end else if (w_timeout) begin
                            w_fault_nx = 1'b1;
                            w_state_nx = HALT;
                        end else begin
                            w_state_nx = DRAIN;
                        end
                    end
                end else if (imem_ack) begin
                    w_instr_nx       = imem_rdata;
                    w_instr_valid_nx = 1'b1;
                    w_state_nx       = HOLD;
                end else if (w_timeout) begin
                    w_fault_nx = 1'b1;
                    w_state_nx = HALT;
                end
            end

            HOLD: begin
                if (redirect) begin
                    w_instr_valid_nx = 1'b0;
                    if (w_redir_bad) begin
                        w_fault_nx = 1'b1;
                        w_state_nx = HALT;
                    end else begin
                        pc_en      = 1'b1;
                        pc_next    = redirect_target;
                        w_state_nx = ISSUE;
                    end
                end else if (instr_ready && !stall) begin
                    pc_en            = 1'b1;
                    w_instr_valid_nx = 1'b0;
                    w_state_nx       = ISSUE;
                end
            end

            DRAIN: begin
                // Address stays put until the outstanding read completes.
                imem_req      = 1'b1;
                w_wait_cnt_nx = r_wait_cnt + CNT_ONE;
                if (redirect) begin
                    if (w_redir_bad) begin
                        w_fault_nx = 1'b1;
                    end else begin
                        pc_en   = 1'b1;
                        pc_next = redirect_target;
                    end
                end
                if (imem_ack) begin
                    w_state_nx = (r_fault || w_redir_bad) ? HALT : ISSUE;
                end else if (w_timeout) begin
                    w_fault_nx = 1'b1;
                    w_state_nx = HALT;
                end
            end

            HALT: begin
                w_instr_valid_nx = 1'b0;
            end

            default: begin
                w_state_nx = BOOT;
            end
        endcase
    end

    assign imem_addr   = r_addr;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign fault       = r_fault;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl with a PC register, a variable-latency memory and a program-order model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] pc_out, pc_next, imem_addr, imem_rdata, instr, redirect_target;
    logic        pc_en, imem_req, imem_ack, instr_valid, instr_ready, stall, redirect, fault;

    logic [31:0] pc2, pc_next2, addr2, rdata2, instr2;
    logic        pc_en2, req2, ack2, valid2, fault2;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          xfers = 0;

    int unsigned mem_dly   = 0;
    logic        mem_never = 1'b0;
    logic [7:0]  m_cnt;

    logic        nx_rst = 1'b1, nx_ready = 1'b1, nx_stall = 1'b0, nx_redirect = 1'b0;
    logic [31:0] nx_target = '0;
    logic        rnd_mode = 1'b0;

    logic [31:0] exp_pc  = '0;
    logic        pending = 1'b0;
    logic        halted  = 1'b0;
    logic [31:0] q2[$];

    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0013;
    endfunction

    fetch_ctrl #(.Reg_size(32), .Reset_vec(32'h0), .Timeout(16)) u_dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .pc_en(pc_en), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .stall(stall),
        .redirect(redirect), .redirect_target(redirect_target), .fault(fault)
    );

    fetch_ctrl #(.Reg_size(32), .Reset_vec(32'hFFFF_FFFC), .Timeout(16)) u_wrap (
        .clk(clk), .rst(rst), .pc_out(pc2), .pc_en(pc_en2), .pc_next(pc_next2),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_rdata(rdata2),
        .instr(instr2), .instr_valid(valid2), .instr_ready(1'b1), .stall(1'b0),
        .redirect(1'b0), .redirect_target(32'h0), .fault(fault2)
    );

    // Program counters with a deliberately odd reset value.
    always_ff @(posedge clk) begin
        if (rst) pc_out <= 32'hDEAD_BEE0;
        else if (pc_en) pc_out <= pc_next;
        if (rst) pc2 <= 32'hDEAD_BEE0;
        else if (pc_en2) pc2 <= pc_next2;
    end

    always_ff @(posedge clk) begin
        if (rst || !imem_req || imem_ack) m_cnt <= '0;
        else m_cnt <= m_cnt + 8'd1;
    end
    assign imem_ack   = imem_req && !mem_never && (int'(m_cnt) >= mem_dly);
    assign imem_rdata = memw(imem_addr);
    assign ack2       = req2;
    assign rdata2     = memw(addr2);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs at the falling edge, then score the cycle against program order.
    task automatic step();
        logic ok_redir;
        @(negedge clk);
        rst = nx_rst;
        if (rnd_mode) begin
            instr_ready     = ($urandom_range(0, 3) != 0);
            stall           = ($urandom_range(0, 3) == 0);
            redirect        = (imem_req || instr_valid) && ($urandom_range(0, 11) == 0);
            redirect_target = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if (!imem_req) mem_dly = $urandom_range(0, 3);
        end else begin
            instr_ready     = nx_ready;
            stall           = nx_stall;
            redirect        = nx_redirect;
            redirect_target = nx_target;
        end
        #1;
        cyc++;
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (req2) q2.push_back(addr2);
            if (valid2) chk("wrap_instr", instr2, memw(pc2));
            if (halted) begin
                chk("halt_fault", fault, 1);
                chk("halt_valid", instr_valid, 0);
            end else begin
                if (imem_req && !pending) chk("req_addr", imem_addr, exp_pc);
                ok_redir = redirect && (imem_req || instr_valid);
                if (ok_redir && redirect_target[1:0] != 2'b00) begin
                    halted = 1'b1;
                end else if (ok_redir) begin
                    exp_pc = redirect_target;
                end else if (instr_valid && instr_ready && !stall) begin
                    chk("xfer_instr", instr, memw(exp_pc));
                    chk("xfer_pc", pc_out, exp_pc);
                    exp_pc = exp_pc + 32'd4;
                    xfers++;
                end
                if (imem_req && imem_ack) pending = 1'b0;
                else if (imem_req) pending = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        nx_rst = 1'b1; nx_redirect = 1'b0; nx_stall = 1'b0; nx_ready = 1'b1;
        rnd_mode = 1'b0; mem_never = 1'b0;
        step();
        step();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_fault", fault, 0);
        chk("rst_addr", imem_addr, 0);
        nx_rst = 1'b0; halted = 1'b0; exp_pc = '0; pending = 1'b0;
        q2.delete();
        step();
        chk("boot_pc_en", pc_en, 1);
        step();
        chk("boot_pc", pc_out, 0);
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 60 && !instr_valid; k++) step();
        chk(tag, instr_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "bench did not finish");
    end

    initial begin
        int          last;
        int          n;
        logic [31:0] hold_i, hold_pc;
        rst = 1'b1; instr_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = '0;

        // Zero-wait streaming: one instruction every three cycles; wrap instance checked too.
        do_reset();
        mem_dly = 0;
        last = -1;
        for (int k = 0; k < 24; k++) begin
            step();
            if (instr_valid) begin
                if (last >= 0) chk("valid_gap", cyc - last, 3);
                last = cyc;
            end
        end
        if (q2.size() < 2) chk("wrap_count", q2.size(), 2);
        else begin
            chk("wrap_first", q2[0], 32'hFFFF_FFFC);
            chk("wrap_second", q2[1], 32'h0);
        end
        chk("wrap_fault", fault2, 0);

        // Stall while holding an instruction.
        do_reset();
        mem_dly  = 3;
        nx_stall = 1'b1;
        wait_valid("t2_valid");
        hold_i  = instr;
        hold_pc = pc_out;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t2_instr_held", instr, hold_i);
            chk("t2_pc_held", pc_out, hold_pc);
            chk("t2_valid_held", instr_valid, 1);
        end
        nx_stall = 1'b0;
        step();
        step();
        chk("t2_pc_adv", pc_out, hold_pc + 32'd4);
        chk("t2_valid_drop", instr_valid, 0);

        // Redirect during an open read at 0x8.
        mem_dly = 2;
        for (int k = 0; k < 60 && !(imem_req && imem_addr == 32'h8); k++) step();
        chk("t3_wait8", imem_addr, 32'h8);
        nx_redirect = 1'b1; nx_target = 32'h100;
        step();
        nx_redirect = 1'b0;
        step();
        chk("t3_drain_req", imem_req, 1);
        chk("t3_drain_addr", imem_addr, 32'h8);
        step();
        chk("t3_issue_pc", pc_out, 32'h100);
        chk("t3_issue_req", imem_req, 0);
        step();
        chk("t3_new_addr", imem_addr, 32'h100);
        nx_stall = 1'b1;
        wait_valid("t3_valid");
        chk("t3_instr", instr, memw(32'h100));

        // Misaligned redirect from HOLD halts until reset.
        nx_redirect = 1'b1; nx_target = 32'h102;
        step();
        nx_redirect = 1'b0; nx_stall = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t4_req_low", imem_req, 0);
        end
        chk("t4_fault", fault, 1);
        do_reset();
        for (int k = 0; k < 10 && !imem_req; k++) step();
        chk("t4_restart_addr", imem_addr, 32'h0);

        // Reset while a read is outstanding, then the timeout.
        mem_never = 1'b1;
        for (int k = 0; k < 3; k++) step();
        chk("t5_req_before_rst", imem_req, 1);
        do_reset();
        mem_never = 1'b1;
        for (int k = 0; k < 10 && !imem_req; k++) step();
        n = 0;
        for (int k = 0; k < 40 && imem_req; k++) begin
            n++;
            step();
        end
        chk("t5_wait_cycles", n, 16);
        chk("t5_fault", fault, 1);
        halted = 1'b1;
        step();
        chk("t5_req_low", imem_req, 0);
        mem_never = 1'b0;

        // Random traffic against the program-order model.
        do_reset();
        rnd_mode = 1'b1;
        for (int k = 0; k < 800; k++) step();
        rnd_mode = 1'b0;
        chk("rnd_fault", fault, 0);
        chk("rnd_progress", (xfers > 50) ? 1 : 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
